// File: rtl/elelock_pkg.sv
// elelock_pkg: shared state encoding, empty-key marker and one-hot keypad decoder for the lock
package elelock_pkg;
    typedef enum logic [1:0] {LOCKED = 2'd0, OPEN = 2'd1, PROGRAM = 2'd2, LOCKOUT = 2'd3} lk_state_t;
    localparam logic [3:0] KEY_NONE = 4'hF;
    function automatic logic [3:0] keyenc(input logic [9:0] k);
        logic [3:0] code;
        int n;
        code = KEY_NONE;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                n++;
                code = 4'(i);
            end
        end
        return (n == 1) ? code : KEY_NONE;
    endfunction
endpackage

// File: rtl/elelock_multi_capture.sv
// keypad_capture: accepts a key only on the first cycle it appears as a clean one-hot press
module keypad_capture
    import elelock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tenkey,
    output logic       key_valid,
    output logic [3:0] key_bcd
);
    logic [9:0] tenkey_q;
    always_ff @(posedge clk) begin
        if (rst) tenkey_q <= '0;
        else tenkey_q <= tenkey;
    end
    assign key_bcd = keyenc(tenkey);
    assign key_valid = (key_bcd != KEY_NONE) && (tenkey_q == '0);
endmodule

// File: rtl/elelock_multi.sv
// elelock_multi: keypad door lock with code buffer, failed-attempt lockout and secret reprogramming
module elelock_multi
    import elelock_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter logic [DIGITS*4-1:0] SECRET = 16'h1234,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tenkey,
    input  logic       enter,
    input  logic       close,
    input  logic       prog,
    output logic       lock,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic [1:0] state_o
);
    localparam int BW = DIGITS * 4;
    localparam int DW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [BW-1:0] CLR = {DIGITS{KEY_NONE}};
    localparam logic [DW-1:0] FULL = DW'(DIGITS);
    localparam logic [TW-1:0] TINIT = TW'(LOCKOUT_CYCLES - 1);
    lk_state_t state, state_n;
    logic [BW-1:0] dbuf, dbuf_n, secret_q, secret_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0] fail_n;
    logic key_valid;
    logic [3:0] key_bcd;
    keypad_capture u_cap (
        .clk(clk),
        .rst(rst),
        .tenkey(tenkey),
        .key_valid(key_valid),
        .key_bcd(key_bcd)
    );
    always_comb begin
        state_n = state;
        dbuf_n = dbuf;
        dcnt_n = dcnt;
        secret_n = secret_q;
        fail_n = fail_cnt;
        timer_n = timer;
        if (key_valid && (state == LOCKED || state == PROGRAM)) begin
            dbuf_n = {dbuf[BW-5:0], key_bcd};
            dcnt_n = (dcnt == FULL) ? dcnt : dcnt + 1'b1;
        end
        // exits below overwrite the shift, so a key coinciding with enter/close is dropped
        case (state)
            LOCKED: if (enter) begin
                dbuf_n = CLR;
                dcnt_n = '0;
                if (dcnt == FULL && dbuf == secret_q) begin
                    state_n = OPEN;
                    fail_n = '0;
                end else begin
                    fail_n = fail_cnt + 1'b1;
                    if (fail_n == 4'(MAX_FAIL)) begin
                        state_n = LOCKOUT;
                        timer_n = TINIT;
                    end
                end
            end
            OPEN: if (close || prog) begin
                state_n = close ? LOCKED : PROGRAM;
                dbuf_n = CLR;
                dcnt_n = '0;
            end
            PROGRAM: if (close || enter) begin
                state_n = close ? LOCKED : OPEN;
                secret_n = (!close && dcnt == FULL) ? dbuf : secret_q;
                dbuf_n = CLR;
                dcnt_n = '0;
            end
            LOCKOUT: if (timer == '0) begin
                state_n = LOCKED;
                fail_n = '0;
                dbuf_n = CLR;
                dcnt_n = '0;
            end else begin
                timer_n = timer - 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOCKED;
            dbuf <= CLR;
            dcnt <= '0;
            secret_q <= SECRET;
            fail_cnt <= '0;
            timer <= '0;
            lock <= 1'b1;
            alarm <= 1'b0;
        end else begin
            state <= state_n;
            dbuf <= dbuf_n;
            dcnt <= dcnt_n;
            secret_q <= secret_n;
            fail_cnt <= fail_n;
            timer <= timer_n;
            lock <= (state_n == LOCKED) || (state_n == LOCKOUT);
            alarm <= (state_n == LOCKOUT);
        end
    end
    assign state_o = state;
endmodule

// File: tb/tb_elelock_multi.sv
// tb_elelock_multi: directed stimulus with a timestamped scoreboard checked by an independent monitor
module tb_elelock_multi;
    typedef struct packed {
        logic [31:0] cyc;
        logic lock;
        logic alarm;
        logic [3:0] fc;
        logic [1:0] st;
        logic chk_buf;
        logic [15:0] bufv;
    } exp_t;
    localparam logic [1:0] S_LK = 2'd0, S_OP = 2'd1, S_PR = 2'd2, S_LO = 2'd3;
    logic clk = 0, rst = 1, enter = 0, close = 0, prog = 0;
    logic [9:0] tenkey = '0;
    logic lock, alarm;
    logic [3:0] fail_cnt;
    logic [1:0] state_o;
    int cyc = 0, total = 0, passed = 0;
    exp_t q[$];
    string names[$];
    elelock_multi #(.DIGITS(4), .SECRET(16'h1234), .MAX_FAIL(3), .LOCKOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .tenkey(tenkey), .enter(enter), .close(close), .prog(prog),
        .lock(lock), .alarm(alarm), .fail_cnt(fail_cnt), .state_o(state_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string n, input logic l, input logic a, input logic [3:0] f,
                              input logic [1:0] s, input logic cb = 0, input logic [15:0] bv = 16'h0);
        q.push_back('{cyc: cyc, lock: l, alarm: a, fc: f, st: s, chk_buf: cb, bufv: bv});
        names.push_back(n);
    endtask
    task automatic key(input int d);
        tenkey = 10'(1 << d);
        tick();
        tenkey = '0;
        tick();
    endtask
    task automatic press_enter();
        enter = 1;
        tick();
        enter = 0;
    endtask
    task automatic pulse_close();
        close = 1;
        tick();
        close = 0;
    endtask
    task automatic code(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
        press_enter();
    endtask
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            string n;
            logic ok;
            e = q.pop_front();
            n = names.pop_front();
            ok = (e.cyc == cyc) && lock == e.lock && alarm == e.alarm && fail_cnt == e.fc &&
                 state_o == e.st && (!e.chk_buf || dut.dbuf == e.bufv);
            total++;
            if (ok) passed++;
            else $display("FAIL %s: got lock=%b alarm=%b fail_cnt=%0d state=%0d buf=%h, want lock=%b alarm=%b fail_cnt=%0d state=%0d buf=%h (chk=%b)",
                          n, lock, alarm, fail_cnt, state_o, dut.dbuf, e.lock, e.alarm, e.fc, e.st, e.bufv, e.chk_buf);
        end
    end
    initial begin
        tick(); tick();
        rst = 0;
        expect_out("reset", 1, 0, 0, S_LK, 1, 16'hFFFF);
        code(1, 2, 3, 4);
        expect_out("t1_open", 0, 0, 0, S_OP);
        total++;
        if (lock === 1'b0 && fail_cnt === 4'd0 && state_o === S_OP) passed++;
        else $display("FAIL d_t1_open: lock=%b fail_cnt=%0d state=%0d", lock, fail_cnt, state_o);
        pulse_close();
        expect_out("t1_close", 1, 0, 0, S_LK, 1, 16'hFFFF);
        tenkey = 10'(1 << 5);
        repeat (6) tick();
        tenkey = '0;
        tick();
        key(6); key(7); key(8);
        expect_out("t2_buf", 1, 0, 0, S_LK, 1, 16'h5678);
        press_enter();
        expect_out("t2_mismatch", 1, 0, 1, S_LK, 1, 16'hFFFF);
        code(1, 2, 3, 4);
        expect_out("t3_open", 0, 0, 0, S_OP);
        pulse_close();
        press_enter();
        expect_out("t3_fail1", 1, 0, 1, S_LK);
        press_enter();
        expect_out("t3_fail2", 1, 0, 2, S_LK);
        press_enter();
        expect_out("t3_lockout", 1, 1, 3, S_LO);
        total++;
        if (alarm === 1'b1 && lock === 1'b1 && state_o === S_LO) passed++;
        else $display("FAIL d_t3_lockout: alarm=%b lock=%b state=%0d", alarm, lock, state_o);
        key(1); key(2);
        press_enter();
        expect_out("t3_ignored", 1, 1, 3, S_LO, 1, 16'hFFFF);
        tick();
        tick();
        expect_out("t3_last_cycle", 1, 1, 3, S_LO);
        tick();
        expect_out("t3_release", 1, 0, 0, S_LK, 1, 16'hFFFF);
        total++;
        if (alarm === 1'b0 && fail_cnt === 4'd0 && state_o === S_LK) passed++;
        else $display("FAIL d_t3_release: alarm=%b fail_cnt=%0d state=%0d", alarm, fail_cnt, state_o);
        code(1, 2, 3, 4);
        expect_out("t3_reopen", 0, 0, 0, S_OP);
        prog = 1;
        tick();
        prog = 0;
        expect_out("t4_program", 0, 0, 0, S_PR);
        code(9, 8, 7, 6);
        expect_out("t4_prog_done", 0, 0, 0, S_OP);
        total++;
        if (state_o === S_OP && dut.secret_q === 16'h9876) passed++;
        else $display("FAIL d_t4_prog_done: state=%0d secret=%h", state_o, dut.secret_q);
        pulse_close();
        code(1, 2, 3, 4);
        expect_out("t4_old_fails", 1, 0, 1, S_LK);
        code(9, 8, 7, 6);
        expect_out("t4_new_opens", 0, 0, 0, S_OP);
        prog = 1;
        tick();
        prog = 0;
        key(1); key(2); key(3);
        press_enter();
        expect_out("t4_abort", 0, 0, 0, S_OP);
        pulse_close();
        code(9, 8, 7, 6);
        expect_out("t4_kept", 0, 0, 0, S_OP);
        key(1); key(2);
        expect_out("t5_open_keys", 0, 0, 0, S_OP, 1, 16'hFFFF);
        pulse_close();
        tenkey = 10'b0000000011;
        tick();
        expect_out("t5_multihot", 1, 0, 0, S_LK, 1, 16'hFFFF);
        tenkey = '0;
        tick();
        key(1); key(2); key(3);
        tenkey = 10'(1 << 4);
        enter = 1;
        tick();
        tenkey = '0;
        enter = 0;
        expect_out("t5_enter_wins", 1, 0, 1, S_LK, 1, 16'hFFFF);
        tick();
        press_enter();
        press_enter();
        expect_out("t6_lockout", 1, 1, 3, S_LO);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        expect_out("t6_reset", 1, 0, 0, S_LK, 1, 16'hFFFF);
        total++;
        if (lock === 1'b1 && alarm === 1'b0 && fail_cnt === 4'd0) passed++;
        else $display("FAIL d_t6_reset: lock=%b alarm=%b fail_cnt=%0d", lock, alarm, fail_cnt);
        code(1, 2, 3, 4);
        expect_out("t6_secret_restored", 0, 0, 0, S_OP);
        total++;
        if (lock === 1'b0 && state_o === S_OP) passed++;
        else $display("FAIL d_t6_secret_restored: lock=%b state=%0d", lock, state_o);
        tick(); tick();
        while (q.size() > 0) begin
            total++;
            $display("FAIL %s: expectation never checked, got none, want cycle %0d", names.pop_front(), q.pop_front().cyc);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
